rr_child_arbiter: RTL
=====================

Name: rr_child_arbiter

Overview:
- Round-robin scheduler that shares one resource slot among the five child instances (inst_0..inst_4) of a generated root module.
- Each child raises a request, receives an exclusive one-hot grant, holds it until it signals done, and then the grant rotates.
- Sits beside the root module. Its grant vector drives the children's enables, so only one child owns the shared datapath at a time.

Parameters:
- NUM_REQ, 5, number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ), width of the encoded grant index.
- HOLD_MAX, 64, maximum grant length in cycles before watchdog release; legal range 2..65535.
- CNT_W, 16, width of the watchdog counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  level request, one bit per child.
- done  input  NUM_REQ  single-cycle release pulse, one bit per child.
- gnt  output  NUM_REQ  registered one-hot grant; all zero when no child owns the resource.
- gnt_id  output  ID_W  encoded index of the current or most recent grantee.
- busy  output  1  high while any gnt bit is high.
- timeout_err  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset values (async assert, sync deassert done externally): gnt=0, gnt_id=0, busy=0, timeout_err=0, rr pointer ptr=0, hold counter=0, state=IDLE.
- All outputs are registered; no combinational path from req or done to any output.
- FSM states are IDLE, GRANT and GAP.
- IDLE: if req!=0, choose winner w = the first set bit of req, searching ptr, ptr+1, ... with wrap modulo NUM_REQ.
  - Next cycle: gnt=1<<w, gnt_id=w, busy=1, counter=0, state=GRANT.
  - Latency from req to gnt is 1 cycle.
- GRANT: counter increments each cycle, saturating at HOLD_MAX. Release is triggered by any of:
  - done[gnt_id]=1;
  - req[gnt_id]=0 (abort);
  - counter==HOLD_MAX-1 (watchdog; timeout_err pulses in the same cycle gnt drops).
- On release: gnt=0, busy=0, ptr=(gnt_id+1) mod NUM_REQ, state=GAP. gnt_id keeps its value.
- done bits for non-granted children are ignored in every state. done in IDLE or GAP is ignored.
- GAP: exactly one cycle with gnt=0. Arbitration uses the updated ptr.
  - If req!=0, go to GRANT with the new winner (gnt high on the next cycle).
  - Otherwise go to IDLE.
  - Back-to-back grants are therefore separated by exactly one idle cycle.
- Simultaneous done and watchdog in the same cycle: treated as a normal done; timeout_err stays 0.
- Fairness: a continuously requesting child waits at most NUM_REQ-1 full grants.
- A requester that is the sole requester is re-granted after one GAP cycle.
- Reset mid-grant: gnt drops immediately (async) and ptr returns to 0.
- NUM_REQ not a power of 2: the ptr wrap is explicit; index values >= NUM_REQ are never produced.

Optional Feature:
- Macro: RR_CHILD_ARBITER_PRIO_EN.
- Defined:
  - Adds input port prio (width NUM_REQ).
  - Arbitration in IDLE and GAP first considers req&prio, using round-robin among those bits. It falls back to plain req only if req&prio==0.
  - ptr update and the watchdog are unchanged.
- Undefined: no prio port; pure round-robin as specified above.

Test Plan:
- Reset, then req=5'b00100 held, with done[2] pulsed 3 cycles after gnt rises. Required: gnt=5'b00100 and gnt_id=2 one cycle after req; gnt=0 the cycle after done; next grant to child 2 again after one GAP cycle.
- req=5'b11111 held; each grantee pulses done 1 cycle after its grant. Required: grant order 0,1,2,3,4,0; exactly one zero-gnt cycle between grants.
- req=5'b10010 with ptr=2. Required: child 4 is granted first, then child 1.
- Grantee 3 never pulses done, HOLD_MAX=64. Required: gnt held for 64 cycles then drops; timeout_err=1 for one cycle; gnt_id=3; next grant goes to child 4 if it is requesting.
- done[0] pulsed while child 2 is granted, and req[2] dropped mid-grant. Required: done[0] is ignored; the req drop releases the grant next cycle with timeout_err=0.
- Assert rst_n=0 while gnt=5'b01000. Required: gnt=0 and busy=0 immediately, without waiting for a clock edge; after release with req=5'b01000, the grant returns 1 cycle later.

Source files
------------

// File: rtl/rr_child_arbiter.sv
// Round-robin single-slot arbiter for the root module's five children; one-hot registered grant.
// Optional macro RR_CHILD_ARBITER_PRIO_EN adds a prio input that biases arbitration.
module rr_child_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int HOLD_MAX = 64,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
`ifdef RR_CHILD_ARBITER_PRIO_EN
  input  logic [NUM_REQ-1:0] prio,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;

  logic [NUM_REQ-1:0] cand;
  logic [ID_W-1:0]    win_id;
  logic               own_done, own_req, wdog_hit;

  // First set bit of c at or after p, wrapping explicitly so no index >= NUM_REQ appears.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                              input logic [ID_W-1:0] p);
    logic [ID_W-1:0] res;
    int              idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(p) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (c[idx]) res = ID_W'(idx);
    end
    return res;
  endfunction

`ifdef RR_CHILD_ARBITER_PRIO_EN
  assign cand = (|(req & prio)) ? (req & prio) : req;
`else
  assign cand = req;
`endif

  assign win_id   = rr_pick(cand, ptr_q);
  assign own_done = done[gnt_id_q];
  assign own_req  = req[gnt_id_q];
  assign wdog_hit = (cnt_q == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    tmo_d    = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        state_d = IDLE;
        if (|cand) begin
          state_d  = GRANT;
          gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
          gnt_id_d = win_id;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        if (cnt_q != CNT_W'(HOLD_MAX)) cnt_d = cnt_q + 1'b1;
        if (own_done || !own_req || wdog_hit) begin
          state_d = GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
          // A done or abort in the watchdog cycle counts as a normal release.
          tmo_d   = !own_done && own_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;

endmodule
